rca_result_stage: RTL and testbench
===================================

RCA_RESULT_STAGE -- requirements
Module: rca_result_stage

Interface
REQ-001 Parameter DEPTH, default 2, number of result-buffer entries; legal values are 2 and 4.
REQ-002 Port clk, input, 1 bit: single clock; all state is on the rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port in_valid, input, 1 bit: the adder/subtractor outputs and operands are valid this cycle.
REQ-005 Port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-006 Port x, input, 8 bits: operand x as presented to the adder/subtractor.
REQ-007 Port y, input, 8 bits: operand y before conditional inversion.
REQ-008 Port op, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 Port z, input, 8 bits: sum/difference from the adder/subtractor.
REQ-010 Port c_out, input, 1 bit: carry out of bit 7 from the adder/subtractor.
REQ-011 Port out_valid, output, 1 bit: the buffer head is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the head this cycle.
REQ-013 Port result, output, 8 bits: the head result.
REQ-014 Port flags, output, 4 bits: the head flags {N, Z, C, V} (bit3..bit0).
REQ-015 Port ovf_count, output, 8 bits: saturating count of accepted entries with V=1.

Function
REQ-016 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-017 in_ready SHALL be 1 exactly when occupancy < DEPTH, independent of out_ready (no pass-through when full).
REQ-018 out_valid SHALL be 1 exactly when occupancy > 0; a push into an empty buffer raises out_valid on the next cycle (latency 1).
REQ-019 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-021 C SHALL equal c_out for both add and subtract (for subtract, C=1 means no borrow).
REQ-022 V SHALL be (x[7]==y[7])&&(z[7]!=x[7]) for add, and (x[7]!=y[7])&&(z[7]!=x[7]) for subtract.
REQ-023 N SHALL be the stored result[7], and Z SHALL be (stored result == 8'h00), both computed after any saturation.
REQ-024 Flags and result SHALL be computed combinationally at push time and stored with the entry.
REQ-025 ovf_count SHALL increment by 1 on each push with V=1 and hold at 8'hFF.
REQ-026 When out_valid=0, result and flags SHALL hold their last value and SHALL not be qualified by the consumer.
REQ-027 Inputs SHALL be ignored while in_ready=0.

Reset
REQ-028 On rst=1, immediately and without a clock: occupancy=0, pointers=0, in_ready=1, out_valid=0, result=8'h00, flags=4'h0, ovf_count=8'h00.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; no pop is reported for them.
REQ-030 The first push is accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 With macro RCA_RESULT_SAT_EN defined, an entry with V=1 SHALL store 8'h7F if x[7]=0, or 8'h80 if x[7]=1, instead of z.
REQ-032 With RCA_RESULT_SAT_EN defined, the C and V flags SHALL still reflect the raw operation, while N and Z reflect the saturated value.
REQ-033 Without RCA_RESULT_SAT_EN, the stored result SHALL always equal z.

Verification
REQ-034 x=7F, y=01, op=0, z=80, c_out=0, out_ready=1 -> next cycle out_valid=1; result=80 with flags=1001 (no SAT), or result=7F with flags=0001 (SAT); ovf_count=1.
REQ-035 x=05, y=05, op=1, z=00, c_out=1 -> result=00, flags=0110.
REQ-036 out_ready=0 with DEPTH=2, 3 pushes presented -> in_ready=0 after 2 pushes; the third entry is held upstream and then accepted after one pop, with FIFO order preserved.
REQ-037 Buffer holding 1 entry, push and pop in the same cycle for 10 cycles -> out_valid stays 1, in_ready stays 1, all 10 results are emitted in order.
REQ-038 300 overflow pushes -> ovf_count=FF; rst asserted mid-stream -> out_valid=0 and ovf_count=00 immediately, before the next clock edge.

Source files
------------

// File: rtl/rca_result_stage.sv
// rtl/rca_result_stage.sv - adder/subtractor result buffer with NZCV flags and overflow counter
// Optional feature macro: RCA_RESULT_SAT_EN (saturate the stored result on signed overflow)
module rca_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       op,
    input  logic [7:0] z,
    input  logic       c_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] result,
    output logic [3:0] flags,
    output logic [7:0] ovf_count
);

    localparam int         AW      = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [2:0]    r_count;
    logic [11:0]   r_last;
    logic [7:0]    r_ovf;

    logic          w_push;
    logic          w_pop;
    logic          w_v;
    logic [7:0]    w_res;
    logic [3:0]    w_flags;
    logic [11:0]   w_head;

    assign in_ready  = (r_count < DEPTH_C);
    assign out_valid = (r_count != 3'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Subtract inverts y's sign bit, so one expression covers both overflow cases.
    assign w_v = (x[7] == (y[7] ^ op)) && (z[7] != x[7]);

`ifdef RCA_RESULT_SAT_EN
    assign w_res = w_v ? (x[7] ? 8'h80 : 8'h7F) : z;
`else
    assign w_res = z;
`endif

    // N and Z follow the stored value; C and V follow the raw operation.
    assign w_flags = {w_res[7], (w_res == 8'h00), c_out, w_v};

    assign w_head    = r_mem[r_rd_ptr];
    assign result    = out_valid ? w_head[7:0]  : r_last[7:0];
    assign flags     = out_valid ? w_head[11:8] : r_last[11:8];
    assign ovf_count = r_ovf;

    // Entry storage: result and flags are captured together at push time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {w_flags, w_res};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 3'd0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 3'd1;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - 3'd1;
        end
    end

    // Remember the head so outputs hold their last value once the buffer drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 12'h000;
        end else if (out_valid) begin
            r_last <= w_head;
        end
    end

    // Saturating count of accepted entries that overflowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 8'h00;
        end else if (w_push && w_v && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'h01;
        end
    end

endmodule

// File: tb/tb_rca_result_stage.sv
// tb/tb_rca_result_stage.sv - directed table-driven bench for rca_result_stage
module tb_rca_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       op;
    logic [7:0] z;
    logic       c_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic [7:0] ovf_count;

    int n_vec = 0;
    int n_err = 0;

    rca_result_stage #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .z         (z),
        .c_out     (c_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       op;
        logic [7:0] z;
        logic       c;
        logic [7:0] exp_res;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(logic [7:0] vx, logic [7:0] vy, logic vop, logic [7:0] vz,
                                logic vc, logic [7:0] er, logic [3:0] ef);
        vec_t v;
        v.x = vx; v.y = vy; v.op = vop; v.z = vz; v.c = vc;
        v.exp_res = er; v.exp_flags = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] vx, input logic [7:0] vy,
                         input logic vop, input logic [7:0] vz, input logic vc);
        in_valid = v; x = vx; y = vy; op = vop; z = vz; c_out = vc;
    endtask

    logic [7:0] exp_ovf;
    int         pushes;
    int         cycles;

    initial begin
        vecs[0] = mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0,
`ifdef RCA_RESULT_SAT_EN
                     8'h7F, 4'b0001);
`else
                     8'h80, 4'b1001);
`endif
        vecs[1] = mk(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 8'h00, 4'b0110);
        vecs[2] = mk(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h30, 4'b0000);
        vecs[3] = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 4'b0110);
        vecs[4] = mk(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1,
`ifdef RCA_RESULT_SAT_EN
                     8'h80, 4'b1011);
`else
                     8'h7F, 4'b0011);
`endif
        vecs[5] = mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1,
`ifdef RCA_RESULT_SAT_EN
                     8'h80, 4'b1011);
`else
                     8'h00, 4'b0111);
`endif
        vecs[6] = mk(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 8'hFE, 4'b1000);
        vecs[7] = mk(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0,
`ifdef RCA_RESULT_SAT_EN
                     8'h7F, 4'b0001);
`else
                     8'h80, 4'b1001);
`endif

        // Reset state, checked before any clock edge.
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags, 4'h0);
        chk("rst_ovf", ovf_count, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Table: push one entry, check head one cycle later, pop, check hold.
        exp_ovf = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].z, vecs[i].c);
            out_ready = 1'b0;
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            @(negedge clk);
            drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
            if (vecs[i].exp_flags[0]) exp_ovf = exp_ovf + 8'h01;
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
            chk($sformatf("v%0d_result", i), result, vecs[i].exp_res);
            chk($sformatf("v%0d_flags", i), flags, vecs[i].exp_flags);
            chk($sformatf("v%0d_ovf", i), ovf_count, exp_ovf);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("v%0d_empty", i), out_valid, 0);
            chk($sformatf("v%0d_hold_result", i), result, vecs[i].exp_res);
            chk($sformatf("v%0d_hold_flags", i), flags, vecs[i].exp_flags);
        end
        chk("table_ovf_total", ovf_count, 8'h04);

        // Full buffer: third entry held upstream until a pop frees a slot.
        drive(1'b1, 8'h00, 8'h00, 1'b0, 8'h11, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'h00, 8'h00, 1'b0, 8'h22, 1'b0);
        chk("full_ready_1", in_ready, 1);
        @(negedge clk);
        drive(1'b1, 8'h00, 8'h00, 1'b0, 8'h33, 1'b0);
        chk("full_ready_2", in_ready, 0);
        @(negedge clk);
        chk("full_still_blocked", in_ready, 0);
        chk("full_head_a", result, 8'h11);
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_ready_after_pop", in_ready, 1);
        chk("full_head_b", result, 8'h22);
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("full_ready_refull", in_ready, 0);
        out_ready = 1'b1;
        chk("full_head_b2", result, 8'h22);
        @(negedge clk);
        chk("full_head_c", result, 8'h33);
        chk("full_valid_c", out_valid, 1);
        @(negedge clk);
        chk("full_drained", out_valid, 0);
        out_ready = 1'b0;

        // Streaming with one entry resident: push and pop every cycle.
        drive(1'b1, 8'h00, 8'h00, 1'b0, 8'h40, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s%0d_valid", i), out_valid, 1);
            chk($sformatf("s%0d_ready", i), in_ready, 1);
            chk($sformatf("s%0d_head", i), result, 8'h40 + 8'(i));
            drive(1'b1, 8'h00, 8'h00, 1'b0, 8'h41 + 8'(i), 1'b0);
            out_ready = 1'b1;
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("s_last_head", result, 8'h4A);
        @(negedge clk);
        chk("s_drained", out_valid, 0);

        // 300 overflow pushes saturate the counter, then a mid-stream reset.
        pushes = 0;
        cycles = 0;
        drive(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
        out_ready = 1'b1;
        while (pushes < 300 && cycles < 2000) begin
            if (in_ready) pushes++;
            @(negedge clk);
            cycles++;
        end
        chk("ovf_push_budget", (pushes == 300), 1);
        chk("ovf_saturated", ovf_count, 8'hFF);
        chk("ovf_busy_before_rst", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_ovf", ovf_count, 8'h00);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_result", result, 8'h00);
        chk("mrst_flags", flags, 4'h0);
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_no_stale_pop", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
